// File: rtl/sha_nonce_sequencer_if.sv
// Core-side stream between sequencer and SHA-256 core:
// valid/newblock/w toward the core, stall and results back.
interface sha_nonce_sequencer_if;
  logic        valid;
  logic        newblock;
  logic [31:0] w;
  logic        stall;
  logic        result_valid;
  logic        result_hit;

  modport master (
    output valid, newblock, w,
    input  stall, result_valid, result_hit
  );

  modport slave (
    input  valid, newblock, w,
    output stall, result_valid, result_hit
  );
endinterface

// File: rtl/sha_nonce_sequencer.sv
// Nonce sweep sequencer: streams one padded 16-word block per
// nonce into the SHA-256 core and matches results to nonces.
// Ports: clk, rst (sync, active-high); job_* dispatcher handshake;
// abort; core (stream + results, master modport); hit_valid/
// hit_nonce; busy; done; err_underflow (sticky).
// Option: SHA_SEQ_STOP_ON_HIT_EN makes a hit in ISSUE act as abort.
module sha_nonce_sequencer #(
  parameter int INFLIGHT_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [31:0] job_w0,
  input  logic [31:0] job_w1,
  input  logic [31:0] job_w2,
  input  logic [31:0] job_nonce_start,
  input  logic [31:0] job_nonce_end,
  input  logic        abort,
  sha_nonce_sequencer_if.master core,
  output logic        hit_valid,
  output logic [31:0] hit_nonce,
  output logic        busy,
  output logic        done,
  output logic        err_underflow
);

  localparam int AW = $clog2(INFLIGHT_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  state_t      state, st_n;
  logic [3:0]  idx, idx_n;
  logic [31:0] nonce, nonce_n;
  logic [31:0] nend, nend_n;
  logic [31:0] w0, w1, w2;
  logic [31:0] w0_n, w1_n, w2_n;
  logic        abort_pend, abort_n;

  logic [31:0]   mem [INFLIGHT_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt, cnt_n;

  logic        consume, push, pop;
  logic        hit_stop, valid_n;
  logic [31:0] word_n;

  always_comb begin
    consume = core.valid & ~core.stall;
    push    = consume & (idx == 4'd15);
    pop     = core.result_valid & (cnt != '0);
    cnt_n   = cnt + CW'(push) - CW'(pop);
`ifdef SHA_SEQ_STOP_ON_HIT_EN
    hit_stop = pop & core.result_hit & (state == ISSUE);
`else
    hit_stop = 1'b0;
`endif
    st_n    = state;
    idx_n   = idx;
    nonce_n = nonce;
    nend_n  = nend;
    w0_n    = w0;
    w1_n    = w1;
    w2_n    = w2;
    abort_n = abort_pend;
    unique case (state)
      IDLE: begin
        if (job_valid) begin
          st_n    = ISSUE;
          idx_n   = 4'd0;
          nonce_n = job_nonce_start;
          nend_n  = job_nonce_end;
          w0_n    = job_w0;
          w1_n    = job_w1;
          w2_n    = job_w2;
          abort_n = 1'b0;
        end
      end
      ISSUE: begin
        abort_n = abort_pend | abort | hit_stop;
        if (consume) begin
          if (idx == 4'd15) begin
            idx_n = 4'd0;
            if ((nonce == nend) || abort_n)
              st_n = DRAIN;
            else
              nonce_n = nonce + 32'd1;
          end else begin
            idx_n = idx + 4'd1;
          end
        end else if ((idx == 4'd0) && abort_n) begin
          // word 0 not yet taken: no block is owed
          st_n = DRAIN;
        end
      end
      DRAIN: begin
        if (cnt == '0)
          st_n = IDLE;
      end
      default: st_n = IDLE;
    endcase

    // word 0 waits for a free in-flight slot
    valid_n = (st_n == ISSUE) &
              ((idx_n != 4'd0) |
               (cnt_n < CW'(INFLIGHT_DEPTH)));

    unique case (idx_n)
      4'd0:    word_n = w0_n;
      4'd1:    word_n = w1_n;
      4'd2:    word_n = w2_n;
      4'd3:    word_n = nonce_n;
      4'd4:    word_n = 32'h8000_0000;
      4'd15:   word_n = 32'h0000_0280;
      default: word_n = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wp] <= nonce;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= 4'd0;
      nonce         <= '0;
      nend          <= '0;
      w0            <= '0;
      w1            <= '0;
      w2            <= '0;
      abort_pend    <= 1'b0;
      wp            <= '0;
      rp            <= '0;
      cnt           <= '0;
      core.valid    <= 1'b0;
      core.newblock <= 1'b0;
      core.w        <= '0;
      hit_valid     <= 1'b0;
      hit_nonce     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      job_ready     <= 1'b1;
      err_underflow <= 1'b0;
    end else begin
      state      <= st_n;
      idx        <= idx_n;
      nonce      <= nonce_n;
      nend       <= nend_n;
      w0         <= w0_n;
      w1         <= w1_n;
      w2         <= w2_n;
      abort_pend <= abort_n;
      cnt        <= cnt_n;
      if (push)
        wp <= wp + AW'(1);
      if (pop)
        rp <= rp + AW'(1);
      core.valid    <= valid_n;
      core.newblock <= valid_n & (idx_n == 4'd0);
      core.w        <= (st_n == ISSUE) ? word_n : '0;
      hit_valid     <= pop & core.result_hit;
      if (pop & core.result_hit)
        hit_nonce <= mem[rp];
      busy      <= (st_n != IDLE);
      job_ready <= (st_n == IDLE);
      done      <= (state == DRAIN) & (st_n == IDLE);
      if (core.result_valid & (cnt == '0))
        err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sha_nonce_sequencer.sv
// Scoreboard bench for sha_nonce_sequencer: expected words and
// hits are queued by stimulus, checked by a negedge monitor.
module tb_sha_nonce_sequencer;

  localparam logic [31:0] W0 = 32'hDEAD_BEEF;
  localparam logic [31:0] W1 = 32'h5F5E_0F00;
  localparam logic [31:0] W2 = 32'h1703_A30C;

  logic        clk = 1'b0;
  logic        rst;
  logic        job_valid;
  logic        job_ready;
  logic [31:0] job_w0, job_w1, job_w2;
  logic [31:0] job_nonce_start, job_nonce_end;
  logic        abort;
  logic        hit_valid;
  logic [31:0] hit_nonce;
  logic        busy, done, err_underflow;

  sha_nonce_sequencer_if core();

  sha_nonce_sequencer #(.INFLIGHT_DEPTH(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .job_valid       (job_valid),
    .job_ready       (job_ready),
    .job_w0          (job_w0),
    .job_w1          (job_w1),
    .job_w2          (job_w2),
    .job_nonce_start (job_nonce_start),
    .job_nonce_end   (job_nonce_end),
    .abort           (abort),
    .core            (core),
    .hit_valid       (hit_valid),
    .hit_nonce       (hit_nonce),
    .busy            (busy),
    .done            (done),
    .err_underflow   (err_underflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_seen = 0;
  int wcount = 0;
  int w0_cyc = 0;
  int w15_cyc = 0;
  logic [32:0] exp_w[$];
  logic [31:0] exp_hit[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // monitor: consumes words, hits and done pulses
  always @(negedge clk) begin
    if (!rst) begin
      if (core.valid && !core.stall) begin
        if (exp_w.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_word got %h want none", core.w);
        end else begin
          logic [32:0] e;
          e = exp_w.pop_front();
          chk("word", {31'h0, core.newblock, core.w}, {31'h0, e});
        end
        if (wcount % 16 == 0) w0_cyc = cyc;
        if (wcount % 16 == 15) w15_cyc = cyc;
        wcount++;
      end
      if (hit_valid) begin
        if (exp_hit.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_hit got %h want none", hit_nonce);
        end else begin
          logic [31:0] h;
          h = exp_hit.pop_front();
          chk("hit_nonce", hit_nonce, h);
        end
      end
      if (done) begin
        done_seen++;
        chk("done_ready", job_ready, 1);
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_block(logic [31:0] n);
    exp_w.push_back({1'b1, W0});
    exp_w.push_back({1'b0, W1});
    exp_w.push_back({1'b0, W2});
    exp_w.push_back({1'b0, n});
    exp_w.push_back({1'b0, 32'h8000_0000});
    for (int i = 0; i < 10; i++)
      exp_w.push_back({1'b0, 32'h0});
    exp_w.push_back({1'b0, 32'h0000_0280});
  endtask

  task automatic start_job(logic [31:0] s, logic [31:0] e);
    job_w0          = W0;
    job_w1          = W1;
    job_w2          = W2;
    job_nonce_start = s;
    job_nonce_end   = e;
    job_valid       = 1'b1;
    tick();
    job_valid       = 1'b0;
  endtask

  task automatic result(logic h);
    core.result_valid = 1'b1;
    core.result_hit   = h;
    tick();
    core.result_valid = 1'b0;
    core.result_hit   = 1'b0;
  endtask

  task automatic wait_done(string nm, int budget);
    int d0;
    int k;
    d0 = done_seen;
    k  = 0;
    while (done_seen == d0 && k < budget) begin
      tick();
      k++;
    end
    tick(3);
    chk({nm, "_done_once"}, done_seen - d0, 1);
    chk({nm, "_idle"}, {busy, job_ready}, 2'b01);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst               = 1'b1;
    job_valid         = 1'b0;
    job_w0            = '0;
    job_w1            = '0;
    job_w2            = '0;
    job_nonce_start   = '0;
    job_nonce_end     = '0;
    abort             = 1'b0;
    core.stall        = 1'b0;
    core.result_valid = 1'b0;
    core.result_hit   = 1'b0;
    tick(3);
    chk("rst_ready", job_ready, 1);
    chk("rst_outs",
        {busy, done, hit_valid, err_underflow,
         core.valid, core.newblock},
        6'b0);
    chk("rst_w", core.w, 0);
    rst = 1'b0;
    tick(2);

    // single nonce
    push_block(32'h0000_1234);
    start_job(32'h0000_1234, 32'h0000_1234);
    chk("t1_first_valid", {core.valid, core.newblock}, 2'b11);
    chk("t1_busy", {busy, job_ready}, 2'b10);
    tick(20);
    chk("t1_left", exp_w.size(), 0);
    chk("t1_valid_off", core.valid, 0);
    exp_hit.push_back(32'h0000_1234);
    result(1'b1);
    wait_done("t1", 20);
    chk("t1_hits_left", exp_hit.size(), 0);

    // wrap-around
    push_block(32'hFFFF_FFFE);
    push_block(32'hFFFF_FFFF);
    push_block(32'h0000_0000);
    push_block(32'h0000_0001);
    start_job(32'hFFFF_FFFE, 32'h0000_0001);
    tick(70);
    chk("t2_left", exp_w.size(), 0);
    exp_hit.push_back(32'hFFFF_FFFF);
    exp_hit.push_back(32'h0000_0000);
    result(1'b0);
    result(1'b1);
    result(1'b1);
    result(1'b0);
    wait_done("t2", 20);
    chk("t2_hits_left", exp_hit.size(), 0);

    // back-pressure: 12 nonces, 8 slots
    for (int i = 0; i < 12; i++)
      push_block(32'h100 + i);
    start_job(32'h100, 32'h10B);
    tick(8 * 16 + 20);
    chk("t3_stalled_valid", core.valid, 0);
    chk("t3_left8", exp_w.size(), 4 * 16);
    for (int i = 0; i < 4; i++) begin
      result(1'b0);
      tick(24);
      chk("t3_release", exp_w.size(), (3 - i) * 16);
    end
    for (int i = 0; i < 8; i++)
      result(1'b0);
    wait_done("t3", 20);

    // stall on word 7
    push_block(32'h0000_0055);
    start_job(32'h0000_0055, 32'h0000_0055);
    tick(7);
    core.stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_hold",
          {core.valid, core.newblock, core.w},
          {2'b10, 32'h0});
      chk("t4_left", exp_w.size(), 9);
    end
    core.stall = 1'b0;
    tick(14);
    chk("t4_block_cycles", w15_cyc - w0_cyc + 1, 21);
    result(1'b0);
    wait_done("t4", 20);

    // abort at word 9 of block 3
    push_block(32'h200);
    push_block(32'h201);
    push_block(32'h202);
    start_job(32'h200, 32'h263);
    tick(32 + 9);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick(30);
    chk("t5_left", exp_w.size(), 0);
    chk("t5_drain", {busy, job_ready, core.valid}, 3'b100);
    begin
      int d0;
      d0 = done_seen;
      result(1'b0);
      result(1'b0);
      tick(3);
      chk("t5_no_early_done", done_seen - d0, 0);
    end
    chk("t5_no_err", err_underflow, 0);
    result(1'b0);
    wait_done("t5", 20);
    result(1'b1);
    tick(2);
    chk("t5_underflow", err_underflow, 1);
    chk("t5_no_hit", hit_valid, 0);

    // hit while issuing
`ifdef SHA_SEQ_STOP_ON_HIT_EN
    push_block(32'h300);
    push_block(32'h301);
`else
    for (int i = 0; i < 6; i++)
      push_block(32'h300 + i);
`endif
    start_job(32'h300, 32'h305);
    tick(20);
    exp_hit.push_back(32'h300);
    result(1'b1);
`ifdef SHA_SEQ_STOP_ON_HIT_EN
    tick(40);
    chk("t6_stopped", core.valid, 0);
    chk("t6_left", exp_w.size(), 0);
    exp_hit.push_back(32'h301);
    result(1'b1);
`else
    tick(4 * 16 + 20);
    chk("t6_left", exp_w.size(), 0);
    for (int i = 0; i < 4; i++)
      result(1'b0);
    exp_hit.push_back(32'h305);
    result(1'b1);
`endif
    wait_done("t6", 20);
    chk("t6_hits_left", exp_hit.size(), 0);
    chk("end_words_left", exp_w.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
